bcd_to_excess3_serial: RTL and testbench
========================================

Name: bcd_to_excess3_serial

Overview:
Bit-serial BCD to Excess-3 encoder. It is the transmit-side counterpart to the team's Excess-3 to BCD decoder.
- Accepts a frame of NUM_DIGITS BCD digits, LSB-first, one bit per accepted cycle.
- Emits the Excess-3 code bit-serially, using a serial add of 0011 with a carry register.
- Flags non-BCD input digits.
- Sits between a parallel-to-serial BCD source and the serial Excess-3 link.

Parameters:
NUM_DIGITS, 2, digits per frame (1..15); frame length is 4*NUM_DIGITS accepted bits.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; opens a new frame (clears all counters and carry)
din_valid  input  1  din carries a valid bit this cycle
din  input  1  BCD bit, LSB of each digit first
busy  output  1  high while a frame is open (CONVERT state)
dout  output  1  Excess-3 bit
dout_valid  output  1  dout valid this cycle
digit_end  output  1  pulses with the 4th output bit of each digit
bcd_err  output  1  pulses with digit_end when that input digit was 1010..1111
frame_done  output  1  pulses with the last output bit of the frame

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE. All outputs 0. bit_idx=0, digit_cnt=0, carry=0, stored bits cleared.
- FSM states:
  - IDLE: din_valid ignored. start -> CONVERT with bit_idx=0, digit_cnt=0, carry=0.
  - CONVERT: each cycle with din_valid=1 accepts one bit. After the last bit of digit NUM_DIGITS-1 -> IDLE.
- start in CONVERT: aborts the current frame and reopens a new one in the same cycle.
  - Any din_valid in that cycle is ignored.
  - No digit_end, bcd_err or frame_done is produced for the aborted frame.
- Serial add, per accepted bit:
  - Addend a = 1 for bit_idx 0 and 1; a = 0 for bit_idx 2 and 3.
  - dout = din ^ a ^ carry.
  - carry_next = majority(din, a, carry).
  - Carry is cleared at bit_idx 3, i.e. the carry out of the MSB is discarded and the result is mod 16.
- Latency: dout and dout_valid are registered and appear exactly 1 cycle after the accepting edge.
  - dout_valid follows din_valid gaps one-for-one.
  - Stall cycles change no state.
- bit_idx is 2 bits wide and wraps 3 -> 0. digit_cnt increments at the wrap.
- Error check: input bits 1 and 2 are stored as they arrive. At bit_idx 3, err = din & (b2 | b1).
  - bcd_err is registered alongside digit_end.
  - Output bits are still the mod-16 sum, e.g. 1010 -> 1101 and 1111 -> 0010.
- digit_end, bcd_err and frame_done are single-cycle pulses, aligned with dout_valid of the relevant bit.
- busy:
  - Rises the cycle after start.
  - Falls the cycle after the final bit is accepted, i.e. the same cycle frame_done is high.
- Back-to-back frames: a start in the same cycle as frame_done is legal. No bits are lost.
- Reset mid-frame: immediate return to reset values. No partial pulses.

Optional Feature:
Macro BCD2XS3_DIGIT_OUT_EN.
- Defined: adds the following ports:
  - digit_out, output, 4 bits: the assembled Excess-3 digit.
  - digit_out_valid, output, 1 bit: coincident with digit_end.
  - A 4-bit shift register assembles the digit. digit_out holds its value until the next digit completes. Reset value 0.
- Undefined: these ports and the shift register do not exist. All other behaviour is identical.

Test Plan:
- Reset released, start, NUM_DIGITS=1, digit 0000 (bits 0,0,0,0) -> dout 1,1,0,0 (0011); digit_end, frame_done on 4th output; bcd_err=0.
- NUM_DIGITS=2, digits 5 then 9, continuous valid -> 0101->1000 then 1001->1100; two digit_end pulses; frame_done on 8th output; busy falls with frame_done.
- Same stream with din_valid low for 3 cycles between bits 2 and 3 -> identical dout sequence; dout_valid gaps match; carry preserved across the stall.
- Digit 1011 -> dout 1110 with bcd_err=1 on digit_end; following digit 0111 -> 1010 with bcd_err=0.
- start asserted after 2 bits of a digit, then digit 3 -> output 0110; no pulses from the aborted frame. Separately, rst_n low mid-digit -> all outputs 0 immediately; busy=0.
- With BCD2XS3_DIGIT_OUT_EN: digits 2,8 -> digit_out=0101 then 1011 on digit_out_valid; value held between digits.

Source files
------------

// File: rtl/bcd_to_excess3_serial.sv
// Bit-serial BCD to Excess-3 encoder.
// Accepts NUM_DIGITS BCD digits LSB-first and adds 0011 to each digit with a
// serial full adder. Flags digits 1010..1111.
// Optional macro BCD2XS3_DIGIT_OUT_EN adds a parallel digit_out/digit_out_valid port pair.
module bcd_to_excess3_serial #(
    parameter int unsigned NUM_DIGITS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       din_valid,
    input  logic       din,
    output logic       busy,
    output logic       dout,
    output logic       dout_valid,
    output logic       digit_end,
    output logic       bcd_err,
    output logic       frame_done
`ifdef BCD2XS3_DIGIT_OUT_EN
    ,
    output logic [3:0] digit_out,
    output logic       digit_out_valid
`endif
);

    localparam int unsigned BIT_W = 2;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [BIT_W-1:0]   bit_idx, bit_idx_n;
    logic [CNT_W-1:0]   digit_cnt, digit_cnt_n;
    logic               carry, carry_n;
    logic               b1, b1_n;
    logic               b2, b2_n;
    logic               busy_n, dout_n, dout_valid_n;
    logic               digit_end_n, bcd_err_n, frame_done_n;
`ifdef BCD2XS3_DIGIT_OUT_EN
    logic [3:0]         shreg, shreg_n;
    logic [3:0]         digit_out_n;
`endif

    logic addend_c;
    logic sum_c;
    logic cout_c;

    // Serial adder: addend is 1 on the two low bits (0011), 0 on the two high bits.
    assign addend_c = ~bit_idx[1];
    assign sum_c    = din ^ addend_c ^ carry;
    assign cout_c   = (din & addend_c) | (din & carry) | (addend_c & carry);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, datapath updates and output pulses.
    always_comb begin
        state_n      = state;
        bit_idx_n    = bit_idx;
        digit_cnt_n  = digit_cnt;
        carry_n      = carry;
        b1_n         = b1;
        b2_n         = b2;
        dout_n       = 1'b0;
        dout_valid_n = 1'b0;
        digit_end_n  = 1'b0;
        bcd_err_n    = 1'b0;
        frame_done_n = 1'b0;
`ifdef BCD2XS3_DIGIT_OUT_EN
        shreg_n      = shreg;
        digit_out_n  = digit_out;
`endif

        if (start) begin
            // Opens a frame; in CONVERT this also abandons the current one.
            state_n     = CONVERT;
            bit_idx_n   = '0;
            digit_cnt_n = '0;
            carry_n     = 1'b0;
            b1_n        = 1'b0;
            b2_n        = 1'b0;
`ifdef BCD2XS3_DIGIT_OUT_EN
            shreg_n     = '0;
`endif
        end else if (state == CONVERT && din_valid) begin
            dout_n       = sum_c;
            dout_valid_n = 1'b1;
            bit_idx_n    = bit_idx + BIT_W'(1);
            carry_n      = cout_c;
`ifdef BCD2XS3_DIGIT_OUT_EN
            shreg_n      = {sum_c, shreg[3:1]};
`endif
            if (bit_idx == BIT_W'(1)) begin
                b1_n = din;
            end
            if (bit_idx == BIT_W'(2)) begin
                b2_n = din;
            end
            if (bit_idx == BIT_W'(3)) begin
                // Carry out of the MSB is dropped: result is mod 16.
                carry_n     = 1'b0;
                digit_end_n = 1'b1;
                bcd_err_n   = din & (b2 | b1);
`ifdef BCD2XS3_DIGIT_OUT_EN
                digit_out_n = {sum_c, shreg[3:1]};
`endif
                if (digit_cnt == LAST_DIGIT) begin
                    frame_done_n = 1'b1;
                    digit_cnt_n  = '0;
                    state_n      = IDLE;
                end else begin
                    digit_cnt_n = digit_cnt + CNT_W'(1);
                end
            end
        end

        busy_n = (state_n == CONVERT);
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx         <= '0;
            digit_cnt       <= '0;
            carry           <= 1'b0;
            b1              <= 1'b0;
            b2              <= 1'b0;
            busy            <= 1'b0;
            dout            <= 1'b0;
            dout_valid      <= 1'b0;
            digit_end       <= 1'b0;
            bcd_err         <= 1'b0;
            frame_done      <= 1'b0;
`ifdef BCD2XS3_DIGIT_OUT_EN
            shreg           <= '0;
            digit_out       <= '0;
            digit_out_valid <= 1'b0;
`endif
        end else begin
            bit_idx         <= bit_idx_n;
            digit_cnt       <= digit_cnt_n;
            carry           <= carry_n;
            b1              <= b1_n;
            b2              <= b2_n;
            busy            <= busy_n;
            dout            <= dout_n;
            dout_valid      <= dout_valid_n;
            digit_end       <= digit_end_n;
            bcd_err         <= bcd_err_n;
            frame_done      <= frame_done_n;
`ifdef BCD2XS3_DIGIT_OUT_EN
            shreg           <= shreg_n;
            digit_out       <= digit_out_n;
            digit_out_valid <= digit_end_n;
`endif
        end
    end

endmodule

// File: tb/tb_bcd_to_excess3_serial.sv
// Scoreboard bench for bcd_to_excess3_serial (NUM_DIGITS = 2).
// Stimulus pushes expected per-bit responses; a negedge monitor pops and compares.
module tb_bcd_to_excess3_serial;

    localparam int unsigned NUM_DIGITS = 2;

    typedef struct packed {
        logic       bit_v;
        logic       de;
        logic       err;
        logic       fd;
        logic [3:0] dig;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic din_valid;
    logic din;
    logic busy;
    logic dout;
    logic dout_valid;
    logic digit_end;
    logic bcd_err;
    logic frame_done;
`ifdef BCD2XS3_DIGIT_OUT_EN
    logic [3:0] digit_out;
    logic       digit_out_valid;
    logic [3:0] last_dig = 4'h0;
`endif

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    bcd_to_excess3_serial #(.NUM_DIGITS(NUM_DIGITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .din_valid  (din_valid),
        .din        (din),
        .busy       (busy),
        .dout       (dout),
        .dout_valid (dout_valid),
        .digit_end  (digit_end),
        .bcd_err    (bcd_err),
        .frame_done (frame_done)
`ifdef BCD2XS3_DIGIT_OUT_EN
        ,
        .digit_out       (digit_out),
        .digit_out_valid (digit_out_valid)
`endif
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every output bit must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (dout_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 32'(dout_valid), 32'(0));
                end else begin
                    e = q.pop_front();
                    chk("dout", 32'(dout), 32'(e.bit_v));
                    chk("digit_end", 32'(digit_end), 32'(e.de));
                    chk("bcd_err", 32'(bcd_err), 32'(e.err));
                    chk("frame_done", 32'(frame_done), 32'(e.fd));
                    chk("busy", 32'(busy), 32'(!e.fd));
`ifdef BCD2XS3_DIGIT_OUT_EN
                    chk("digit_out_valid", 32'(digit_out_valid), 32'(e.de));
                    if (e.de) last_dig = e.dig;
                    chk("digit_out", 32'(digit_out), 32'(last_dig));
`endif
                end
            end else begin
                chk("idle_pulse", 32'({digit_end, bcd_err, frame_done}), 32'(0));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            din_valid = 1'b0;
            din       = 1'b1;
            @(posedge clk); #1;
        end
        din = 1'b0;
    endtask

    task automatic do_start(input logic dv);
        start     = 1'b1;
        din_valid = dv;
        din       = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        din_valid = 1'b0;
        din       = 1'b0;
        chk("busy_rise", 32'(busy), 32'(1));
    endtask

    task automatic accept_bit(input logic b, input exp_t e, input bit push);
        din       = b;
        din_valid = 1'b1;
        if (push) q.push_back(e);
        @(posedge clk); #1;
        din_valid = 1'b0;
        din       = 1'b0;
    endtask

    // Sends bits [first..last_bit] of digit d; optional stall before bit stall_at.
    task automatic send_digit(input int d, input bit last, input int first,
                              input int last_bit, input int stall_at, input int stall_len);
        logic [3:0] bv;
        logic [3:0] xv;
        exp_t       e;
        bv = 4'(d);
        xv = 4'((d + 3) % 16);
        for (int i = first; i <= last_bit; i++) begin
            if (i == stall_at) idle(stall_len);
            e.bit_v = xv[i];
            e.de    = (i == 3);
            e.err   = (i == 3) && (d > 9);
            e.fd    = (i == 3) && last;
            e.dig   = xv;
            accept_bit(bv[i], e, 1'b1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        exp_t dummy;
        dummy     = '0;
        rst_n     = 1'b0;
        start     = 1'b0;
        din_valid = 1'b0;
        din       = 1'b0;
        #12;
        chk("reset_outputs", 32'({busy, dout, dout_valid, digit_end, bcd_err, frame_done}), 32'(0));
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // IDLE ignores din_valid.
        send_digit(5, 1'b0, 0, -1, -1, 0);
        accept_bit(1'b1, dummy, 1'b0);
        accept_bit(1'b1, dummy, 1'b0);
        idle(2);
        chk("idle_busy", 32'(busy), 32'(0));

        // Zero digits: 0000 -> 0011.
        do_start(1'b0);
        send_digit(0, 1'b0, 0, 3, -1, 0);
        send_digit(0, 1'b1, 0, 3, -1, 0);

        // 5 then 9, continuous, back-to-back into the next frame.
        do_start(1'b0);
        send_digit(5, 1'b0, 0, 3, -1, 0);
        send_digit(9, 1'b1, 0, 3, -1, 0);

        // Back-to-back start in the frame_done cycle, same stream with a stall.
        do_start(1'b0);
        send_digit(5, 1'b0, 0, 3, 2, 3);
        send_digit(9, 1'b1, 0, 3, 3, 2);
        idle(2);

        // Non-BCD digit followed by a legal one.
        do_start(1'b0);
        send_digit(11, 1'b0, 0, 3, -1, 0);
        send_digit(7, 1'b1, 0, 3, -1, 0);
        do_start(1'b0);
        send_digit(15, 1'b0, 0, 3, -1, 0);
        send_digit(10, 1'b1, 0, 3, -1, 0);

        // Abort after two bits; din_valid in the start cycle is dropped.
        do_start(1'b0);
        send_digit(6, 1'b0, 0, 1, -1, 0);
        do_start(1'b1);
        send_digit(3, 1'b0, 0, 3, -1, 0);
        send_digit(0, 1'b1, 0, 3, -1, 0);

        // Digits 2, 8 with gaps between digits.
        do_start(1'b0);
        send_digit(2, 1'b0, 0, 3, -1, 0);
        idle(3);
        send_digit(8, 1'b1, 0, 3, -1, 0);
        idle(2);

        // Reset mid-digit while an output bit is on the wire.
        do_start(1'b0);
        send_digit(9, 1'b0, 0, 0, -1, 0);
        accept_bit(1'b0, dummy, 1'b0);
        chk("pre_reset_valid", 32'(dout_valid), 32'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", 32'({busy, dout, dout_valid, digit_end, bcd_err, frame_done}), 32'(0));
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        accept_bit(1'b1, dummy, 1'b0);
        accept_bit(1'b1, dummy, 1'b0);
        chk("post_reset_busy", 32'(busy), 32'(0));

        // Fresh frame after reset.
        do_start(1'b0);
        send_digit(4, 1'b0, 0, 3, -1, 0);
        send_digit(1, 1'b1, 0, 3, -1, 0);

        idle(4);
        chk("queue_empty", 32'(q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
